// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: shared ALU, internal IMEM/DMEM, 32x32 register file, trace outputs.
// Optional MULTICYCLE_PERF_COUNTERS_EN adds cycle_count / instr_count outputs.
module multicycle_datapath #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   pc_out,
  output logic [31:0]                   alu_out,
  output logic [2:0]                    state_out,
  output logic                          instr_done,
  output logic                          halted,
  output logic                          illegal
`ifdef MULTICYCLE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                   cycle_count,
  output logic [31:0]                   instr_count
`endif
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_fn_t;
  typedef enum logic [1:0] {SRCB_FOUR, SRCB_B, SRCB_IMM, SRCB_BR} srcb_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, ir_reg, a_reg, b_reg, mdr_reg, aluout_reg;
  logic        illegal_reg;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf   [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [25:0] imm26;
  logic [31:0] imm_sext;
  logic        funct_ok;

  assign op       = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign funct    = ir_reg[5:0];
  assign imm26    = ir_reg[25:0];
  assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};

  always_comb begin
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                               funct_ok = 1'b0;
    endcase
  end

  // Control strobes produced by the output process
  logic    srca_pc;
  srcb_t   srcb_sel;
  alu_fn_t alu_fn;
  logic    ir_we, ab_we, aluout_we, mdr_we, dmem_we, rf_we;
  logic    rf_dst_rd, rf_from_mdr;
  logic    pc_inc, pc_branch, pc_jump;
  logic    illegal_set, done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_RTYPE:     state_next = funct_ok ? S_WB : S_HALT;
          OP_LW, OP_SW: state_next = S_MEM;
          OP_ADDI:      state_next = S_WB;
          OP_BEQ, OP_J: state_next = S_FETCH;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEM:    state_next = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    srca_pc     = 1'b1;
    srcb_sel    = SRCB_FOUR;
    alu_fn      = ALU_ADD;
    ir_we       = 1'b0;
    ab_we       = 1'b0;
    aluout_we   = 1'b0;
    mdr_we      = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    rf_dst_rd   = 1'b0;
    rf_from_mdr = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    pc_jump     = 1'b0;
    illegal_set = 1'b0;
    done        = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_we  = 1'b1;
        pc_inc = 1'b1;
      end
      // pc already points past this instruction, so the branch target is pc+4+off*4
      S_DECODE: begin
        ab_we     = 1'b1;
        aluout_we = 1'b1;
        srcb_sel  = SRCB_BR;
      end
      S_EXEC: begin
        srca_pc = 1'b0;
        case (op)
          OP_RTYPE: begin
            srcb_sel    = SRCB_B;
            aluout_we   = funct_ok;
            illegal_set = !funct_ok;
            case (funct)
              FN_SUB:  alu_fn = ALU_SUB;
              FN_AND:  alu_fn = ALU_AND;
              FN_OR:   alu_fn = ALU_OR;
              FN_SLT:  alu_fn = ALU_SLT;
              default: alu_fn = ALU_ADD;
            endcase
          end
          OP_LW, OP_SW, OP_ADDI: begin
            srcb_sel  = SRCB_IMM;
            aluout_we = 1'b1;
          end
          OP_BEQ: begin
            pc_branch = (a_reg == b_reg);
            done      = 1'b1;
          end
          OP_J: begin
            pc_jump = 1'b1;
            done    = 1'b1;
          end
          OP_HALT: ;
          default: illegal_set = 1'b1;
        endcase
      end
      S_MEM: begin
        if (op == OP_LW) begin
          mdr_we = 1'b1;
        end else begin
          dmem_we = 1'b1;
          done    = 1'b1;
        end
      end
      S_WB: begin
        rf_we       = 1'b1;
        rf_dst_rd   = (op == OP_RTYPE);
        rf_from_mdr = (op == OP_LW);
        done        = 1'b1;
      end
      default: ;
    endcase
  end

  logic [31:0] alu_a, alu_b, alu_y;

  assign alu_a = srca_pc ? pc_reg : a_reg;

  always_comb begin
    case (srcb_sel)
      SRCB_FOUR: alu_b = 32'd4;
      SRCB_B:    alu_b = b_reg;
      SRCB_IMM:  alu_b = imm_sext;
      default:   alu_b = {imm_sext[29:0], 2'b00};
    endcase
    case (alu_fn)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      mdr_reg     <= '0;
      aluout_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      if (ir_we) ir_reg <= imem[pc_reg[IW+1:2]];
      if (pc_inc) begin
        pc_reg <= alu_y;
      end else if (pc_branch) begin
        pc_reg <= aluout_reg;
      end else if (pc_jump) begin
        pc_reg <= {pc_reg[31:28], imm26, 2'b00};
      end
      if (ab_we) begin
        a_reg <= rf[rs];
        b_reg <= rf[rt];
      end
      if (aluout_we) aluout_reg <= alu_y;
      if (mdr_we) mdr_reg <= dmem[aluout_reg[DW+1:2]];
      if (illegal_set) illegal_reg <= 1'b1;
    end
  end

  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign rf_waddr = rf_dst_rd ? rd : rt;
  assign rf_wdata = rf_from_mdr ? mdr_reg : aluout_reg;

  // R0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (dmem_we && !reset) dmem[aluout_reg[DW+1:2]] <= b_reg;
  end

  // Loading is only allowed while the core is not fetching
  always_ff @(posedge clock) begin
    if (imem_we && (reset || halted)) imem[imem_waddr] <= imem_wdata;
  end

  assign pc_out     = pc_reg;
  assign alu_out    = aluout_reg;
  assign state_out  = state_reg;
  assign instr_done = done;
  assign halted     = (state_reg == S_HALT);
  assign illegal    = illegal_reg;

`ifdef MULTICYCLE_PERF_COUNTERS_EN
  logic [31:0] cycle_count_reg, instr_count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count_reg <= '0;
      instr_count_reg <= '0;
    end else begin
      if (state_reg != S_HALT) cycle_count_reg <= cycle_count_reg + 32'd1;
      if (done) instr_count_reg <= instr_count_reg + 32'd1;
    end
  end

  assign cycle_count = cycle_count_reg;
  assign instr_count = instr_count_reg;
`endif

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle MIPS-subset processor core; the next generation of the team's single-cycle datapath.
- Each instruction is split into 3–5 FSM states, and one shared ALU does PC increment, branch target and execute work.
- Internal instruction memory, data memory and a 32x32 register file; external writes load the instruction memory.
- Sits at the top of the lab CPU hierarchy and drives trace outputs for the bench.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of 2, ≥4)
DMEM_WORDS, 64, data memory depth in 32-bit words (power of 2, ≥4)
RESET_PC, 0, byte address loaded into PC on reset (word aligned)

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-high
imem_we  input  1  instruction memory load strobe
imem_waddr  input  log2(IMEM_WORDS)  word index to load
imem_wdata  input  32  instruction word to load
pc_out  output  32  current PC (byte address)
alu_out  output  32  registered ALU result (ALUOut register)
state_out  output  3  FSM state encoding
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
halted  output  1  core stopped (HALT or illegal opcode)
illegal  output  1  sticky; set when an unsupported opcode/funct is decoded

Behaviour:
- Reset (sync, on posedge with reset=1):
  - pc=RESET_PC, state=FETCH.
  - IR, A, B, MDR, ALUOut cleared; all 32 registers cleared.
  - instr_done=0, halted=0, illegal=0.
  - IMEM and DMEM contents are preserved.
  - Reset mid-instruction aborts it; no register or memory write occurs on that edge.
- IMEM load: writes only when reset=1 or halted=1; ignored otherwise.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: IR<=IMEM[pc[..:2] mod IMEM_WORDS]; pc<=pc+4.
- DECODE: A<=R[rs], B<=R[rt]; ALUOut<=pc+(signext(imm)<<2) (branch target).
- EXEC, by opcode:
  - R-type (op 00): ALUOut<=A op B. Funct 20 add, 22 sub, 24 and, 25 or, 2A slt (signed).
  - lw (23) / sw (2B) / addi (08): ALUOut<=A+signext(imm).
  - beq (04): if A==B then pc<=ALUOut; then FETCH, instr_done=1.
  - j (02): pc<={pc[31:28],imm26,2'b00}; then FETCH, instr_done=1.
  - HALT (3F): go to HALT, halted=1.
  - Any other opcode or funct: go to HALT, halted=1, illegal=1.
- MEM:
  - lw: MDR<=DMEM[ALUOut[..:2] mod DMEM_WORDS]; next WB.
  - sw: DMEM[...]<=B; then FETCH, instr_done=1.
- WB:
  - R-type: R[rd]<=ALUOut.
  - addi: R[rt]<=ALUOut.
  - lw: R[rt]<=MDR.
  - Then FETCH, instr_done=1.
- Instruction latency in cycles: beq/j 3; R-type/addi/sw 4; lw 5.
- R0 is hardwired zero; writes to it are discarded.
- Arithmetic is 32-bit, wrap-around, no overflow trap.
- Address bits [1:0] are ignored; memory indices wrap modulo depth.
- PC wraps at 2^32.
- HALT state is held until reset; pc, registers and memories are frozen.
- alu_out and pc_out reflect registered values (no combinational path from inputs).

Optional Feature:
- Macro: MULTICYCLE_PERF_COUNTERS_EN.
- When defined:
  - Adds outputs cycle_count[31:0] and instr_count[31:0]. Both are cleared on reset.
  - cycle_count increments every non-HALT cycle.
  - instr_count increments on every instr_done pulse.
  - Both wrap at 2^32.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Program load:
  - Stimulus: hold reset, load addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; HALT; then release reset.
  - Response: R3=12; halted=1 after 4+4+4+3=15 cycles; instr_done pulses 3 times.
- Load/store:
  - Stimulus: addi $1,$0,0x1234; sw $1,8($0); lw $4,8($0); HALT.
  - Response: DMEM[2]=0x1234; R4=0x1234; the lw occupies exactly 5 cycles.
- Branching:
  - Stimulus: beq $0,$0,+1 skipping an addi $5,$0,1.
  - Response: R5 stays 0; pc advances by 8.
  - Stimulus: j 0 at address 12.
  - Response: pc=0 at the next FETCH.
- Boundaries:
  - Stimulus: sub $6,$0,$1 with R1=1.
  - Response: R6=0xFFFFFFFF; slt $7,$6,$0 gives R7=1.
  - Stimulus: addi $0,$0,9.
  - Response: R0 stays 0.
- Reset mid-lw:
  - Stimulus: assert reset in the MEM state of a lw.
  - Response: target register is unchanged, state=0, pc=RESET_PC, DMEM unchanged.
  - Stimulus: imem_we asserted while running.
  - Response: IMEM is unmodified.
- Illegal opcode and counters:
  - Stimulus: opcode 0x3E.
  - Response: illegal=1, halted=1, state_out=5.
  - With MULTICYCLE_PERF_COUNTERS_EN defined, on the program from the program-load scenario.
  - Response: instr_count=3 and cycle_count=15 at halt.
